// File: rtl/timer_multi.sv
// ---------------------------------------------------------------------------
// timer_multi
//
// Multi-channel APB timer peripheral. There are N_CH independent WIDTH-bit
// up-counters. Each channel has its own 16-bit prescaler, an equality compare
// register, a periodic or one-shot mode, sticky write-1-to-clear status flags
// and maskable level interrupts.
//
// Register map per channel (base = ch*16):
//   0x0 CNT   counter value (zero-extended on read)
//   0x4 CFG   [0] EN, [1] ONESHOT, [2] CMP_IE, [3] OVF_IE, [11:8] PRSC
//   0x8 CMP   compare value
//   0xC STAT  [0] CMP flag, [1] OVF flag (write 1 to clear)
//
// Optional feature macro: TIMER_MULTI_OVF_EN
//   defined     -> overflow flag, OVF_IE and overflow interrupt present
//   not defined -> STAT[1]/CFG[3] read 0, counter wraps silently
//
// Ports:
//   PCLK      sole clock
//   PRESET    synchronous active-high reset
//   PSEL      APB select
//   PENABLE   APB access phase
//   PWRITE    1 = write
//   PADDR     byte address: [AW-1:4] channel, [3:2] register
//   PWDATA    write data
//   PRDATA    read data (access phase only, otherwise 0)
//   PREADY    high in every access phase (no wait states)
//   PSLVERR   high in access phase for a nonexistent channel
//   irq_o     per-channel level interrupt
// ---------------------------------------------------------------------------
module timer_multi #(
    parameter int  N_CH  = 4,
    parameter int  WIDTH = 32,
    localparam int AW    = $clog2(N_CH) + 4
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic            PWRITE,
    input  logic [AW-1:0]   PADDR,
    input  logic [31:0]     PWDATA,
    output logic [31:0]     PRDATA,
    output logic            PREADY,
    output logic            PSLVERR,
    output logic [N_CH-1:0] irq_o
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] r_cnt     [N_CH];
    logic [WIDTH-1:0] r_cmp     [N_CH];
    logic [15:0]      r_prsc    [N_CH];
    logic [3:0]       r_cfgPrsc [N_CH];
    logic [N_CH-1:0]  r_cfgEn;
    logic [N_CH-1:0]  r_cfgOneshot;
    logic [N_CH-1:0]  r_cfgCmpIe;
    logic [N_CH-1:0]  r_stCmp;

    logic [N_CH-1:0]  w_ovfIe;
    logic [N_CH-1:0]  w_stOvf;

`ifdef TIMER_MULTI_OVF_EN
    logic [N_CH-1:0]  r_cfgOvfIe;
    logic [N_CH-1:0]  r_stOvf;
    assign w_ovfIe = r_cfgOvfIe;
    assign w_stOvf = r_stOvf;
`else
    assign w_ovfIe = '0;
    assign w_stOvf = '0;
`endif

    // Address decode. The channel index is widened to 32 bits so that a
    // single-channel build (no channel bits in PADDR) still decodes cleanly.
    logic [31:0]     w_chIdx;
    logic [1:0]      w_reg;
    logic            w_inRange;
    logic            w_access;
    logic            w_write;
    logic            w_unusedAddr;
    logic [N_CH-1:0] w_wrCnt;
    logic [N_CH-1:0] w_wrCfg;
    logic [N_CH-1:0] w_wrCmp;
    logic [N_CH-1:0] w_wrStat;
    logic [N_CH-1:0] w_tick;
    logic [31:0]     w_rdData;

    assign w_chIdx      = 32'(PADDR) >> 4;
    assign w_reg        = PADDR[3:2];
    assign w_unusedAddr = ^PADDR[1:0];
    assign w_inRange    = w_chIdx < 32'(N_CH);
    assign w_access     = PSEL & PENABLE;
    assign w_write      = w_access & PWRITE & w_inRange;

    always_comb begin
        w_wrCnt  = '0;
        w_wrCfg  = '0;
        w_wrCmp  = '0;
        w_wrStat = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_write && (w_chIdx == 32'(c))) begin
                w_wrCnt[c]  = (w_reg == 2'd0);
                w_wrCfg[c]  = (w_reg == 2'd1);
                w_wrCmp[c]  = (w_reg == 2'd2);
                w_wrStat[c] = (w_reg == 2'd3);
            end
        end
    end

    // A tick fires when the prescaler reaches 2^PRSC-1, so PRSC=0 ticks on
    // every enabled cycle.
    always_comb begin
        w_tick = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_tick[c] = r_cfgEn[c] &&
                        (r_prsc[c] == ((16'd1 << r_cfgPrsc[c]) - 16'd1));
        end
    end

    // Channel state. Statement order sets the priorities: W1C clears come
    // first so a same-cycle hardware set wins; a CNT write suppresses the
    // tick entirely (no flags); a CFG write overrides the one-shot EN clear.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int c = 0; c < N_CH; c++) begin
                r_cnt[c]     <= '0;
                r_cmp[c]     <= ONES;
                r_prsc[c]    <= '0;
                r_cfgPrsc[c] <= '0;
            end
            r_cfgEn      <= '0;
            r_cfgOneshot <= '0;
            r_cfgCmpIe   <= '0;
            r_stCmp      <= '0;
`ifdef TIMER_MULTI_OVF_EN
            r_cfgOvfIe   <= '0;
            r_stOvf      <= '0;
`endif
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_wrStat[c] && PWDATA[0]) r_stCmp[c] <= 1'b0;
`ifdef TIMER_MULTI_OVF_EN
                if (w_wrStat[c] && PWDATA[1]) r_stOvf[c] <= 1'b0;
`endif
                if (r_cfgEn[c]) begin
                    r_prsc[c] <= w_tick[c] ? 16'd0 : r_prsc[c] + 16'd1;
                end

                // Compare is checked before overflow, so CMP=all-ones never
                // raises the overflow flag.
                if (w_tick[c] && !w_wrCnt[c]) begin
                    if (r_cnt[c] == r_cmp[c]) begin
                        r_cnt[c]   <= '0;
                        r_stCmp[c] <= 1'b1;
                        if (r_cfgOneshot[c]) r_cfgEn[c] <= 1'b0;
                    end
`ifdef TIMER_MULTI_OVF_EN
                    else if (r_cnt[c] == ONES) begin
                        r_cnt[c]   <= '0;
                        r_stOvf[c] <= 1'b1;
                    end
`endif
                    else begin
                        r_cnt[c] <= r_cnt[c] + WIDTH'(1);
                    end
                end

                if (w_wrCnt[c]) begin
                    r_cnt[c]  <= PWDATA[WIDTH-1:0];
                    r_prsc[c] <= '0;
                end
                if (w_wrCfg[c]) begin
                    r_cfgEn[c]      <= PWDATA[0];
                    r_cfgOneshot[c] <= PWDATA[1];
                    r_cfgCmpIe[c]   <= PWDATA[2];
`ifdef TIMER_MULTI_OVF_EN
                    r_cfgOvfIe[c]   <= PWDATA[3];
`endif
                    r_cfgPrsc[c]    <= PWDATA[11:8];
                    r_prsc[c]       <= '0;
                end
                if (w_wrCmp[c]) begin
                    r_cmp[c] <= PWDATA[WIDTH-1:0];
                end
            end
        end
    end

    // Read mux straight from current register state.
    always_comb begin
        w_rdData = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_chIdx == 32'(c)) begin
                case (w_reg)
                    2'd0:    w_rdData = 32'(r_cnt[c]);
                    2'd1:    w_rdData = {20'd0, r_cfgPrsc[c], 4'd0, w_ovfIe[c],
                                         r_cfgCmpIe[c], r_cfgOneshot[c], r_cfgEn[c]};
                    2'd2:    w_rdData = 32'(r_cmp[c]);
                    default: w_rdData = {30'd0, w_stOvf[c], r_stCmp[c]};
                endcase
            end
        end
    end

    // Bus outputs are forced low while reset is held.
    assign PRDATA  = (w_access && w_inRange && !PRESET) ? w_rdData : 32'd0;
    assign PREADY  = w_access && !PRESET;
    assign PSLVERR = w_access && !w_inRange && !PRESET;

    assign irq_o = (r_stCmp & r_cfgCmpIe) | (w_stOvf & w_ovfIe);

endmodule
